// File: rtl/ball_if.sv
// Handshake bundle between the frame sequencer and the ball position generator.
// The master issues move/enable; the slave returns the committed position and status.
interface ball_if #(
    parameter int h_bits = 10,
    parameter int v_bits = 10
);
    logic              ball_en;
    logic              move;
    logic [h_bits-1:0] h_pos;
    logic [v_bits-1:0] v_pos;
    logic              busy;
    logic [3:0]        hit_wall;

    modport master (
        output ball_en,
        output move,
        input  h_pos,
        input  v_pos,
        input  busy,
        input  hit_wall
    );

    modport slave (
        input  ball_en,
        input  move,
        output h_pos,
        output v_pos,
        output busy,
        output hit_wall
    );
endinterface

// File: rtl/ball_motion.sv
// Bouncing-ball centre generator: one step per move strobe, reflecting off the edges.
// X and Y are computed in separate cycles and published together in a single commit.
module ball_motion #(
    parameter int width       = 1024,
    parameter int height      = 768,
    parameter int ball_radius = 16,
    parameter int init_x      = 512,
    parameter int init_y      = 384,
    parameter int step_x      = 2,
    parameter int step_y      = 2
) (
    input logic   clk,
    input logic   reset,
    ball_if.slave bus
);
    localparam int XW = $clog2(width);
    localparam int YW = $clog2(height);

    typedef logic [XW-1:0] h_t;
    typedef logic [YW-1:0] v_t;
    typedef logic [XW:0]   xw_t;
    typedef logic [YW:0]   yw_t;

    localparam xw_t X_LO = xw_t'(ball_radius);
    localparam xw_t X_HI = xw_t'(width - 1 - ball_radius);
    localparam xw_t X_ST = xw_t'(step_x);
    localparam yw_t Y_LO = yw_t'(ball_radius);
    localparam yw_t Y_HI = yw_t'(height - 1 - ball_radius);
    localparam yw_t Y_ST = yw_t'(step_y);

    typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;

    state_t     state;
    logic       busy_q;
    h_t         h_q;
    v_t         v_q;
    logic       dir_x;
    logic       dir_y;
    h_t         nx;
    v_t         ny;
    logic       ndir_x;
    logic       ndir_y;
    logic [1:0] hx;
    logic [1:0] hy;
    logic [3:0] hit_q;

    xw_t        px, x_up, x_dn, x_next;
    logic       x_dir;
    logic [1:0] x_hit;
    yw_t        py, y_up, y_dn, y_next;
    logic       y_dir;
    logic [1:0] y_hit;

    assign px   = xw_t'(h_q);
    assign x_up = px + X_ST;
    assign x_dn = px - X_ST;
    assign py   = yw_t'(v_q);
    assign y_up = py + Y_ST;
    assign y_dn = py - Y_ST;

    // dir=1 moves toward hi; hit bits are {hi_side, lo_side}
    always_comb begin
        x_next = px;
        x_dir  = dir_x;
        x_hit  = 2'b00;
        if (dir_x) begin
            if (x_up >= X_HI) begin
                x_next = X_HI;
                x_dir  = 1'b0;
                x_hit  = 2'b10;
            end else if (x_up < X_LO) begin
                x_next = X_LO;
            end else begin
                x_next = x_up;
            end
        end else begin
            if (px <= X_LO + X_ST) begin
                x_next = X_LO;
                x_dir  = 1'b1;
                x_hit  = 2'b01;
            end else if (x_dn > X_HI) begin
                x_next = X_HI;
            end else begin
                x_next = x_dn;
            end
        end
    end

    always_comb begin
        y_next = py;
        y_dir  = dir_y;
        y_hit  = 2'b00;
        if (dir_y) begin
            if (y_up >= Y_HI) begin
                y_next = Y_HI;
                y_dir  = 1'b0;
                y_hit  = 2'b10;
            end else if (y_up < Y_LO) begin
                y_next = Y_LO;
            end else begin
                y_next = y_up;
            end
        end else begin
            if (py <= Y_LO + Y_ST) begin
                y_next = Y_LO;
                y_dir  = 1'b1;
                y_hit  = 2'b01;
            end else if (y_dn > Y_HI) begin
                y_next = Y_HI;
            end else begin
                y_next = y_dn;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            h_q    <= h_t'(init_x);
            v_q    <= v_t'(init_y);
            dir_x  <= 1'b1;
            dir_y  <= 1'b1;
            nx     <= '0;
            ny     <= '0;
            ndir_x <= 1'b1;
            ndir_y <= 1'b1;
            hx     <= 2'b00;
            hy     <= 2'b00;
            hit_q  <= 4'b0000;
        end else begin
            hit_q <= 4'b0000;
            unique case (state)
                IDLE: begin
                    if (bus.move && bus.ball_en) begin
                        state  <= CALC_X;
                        busy_q <= 1'b1;
                    end
                end
                CALC_X: begin
                    nx     <= x_next[XW-1:0];
                    ndir_x <= x_dir;
                    hx     <= x_hit;
                    state  <= CALC_Y;
                end
                CALC_Y: begin
                    ny     <= y_next[YW-1:0];
                    ndir_y <= y_dir;
                    hy     <= y_hit;
                    state  <= COMMIT;
                end
                COMMIT: begin
                    h_q    <= nx;
                    v_q    <= ny;
                    dir_x  <= ndir_x;
                    dir_y  <= ndir_y;
                    hit_q  <= {hy, hx};
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.h_pos    = h_q;
    assign bus.v_pos    = v_q;
    assign bus.busy     = busy_q;
    assign bus.hit_wall = hit_q;
endmodule

// File: tb/tb_ball_motion.sv
// Randomised scoreboard bench: a centre instance and a corner-start instance
// share stimulus; a reference model predicts each commit and a monitor checks it.
module tb_ball_motion;
    localparam int X_LO = 16;
    localparam int X_HI = 1007;
    localparam int Y_LO = 16;
    localparam int Y_HI = 751;
    localparam int ST   = 2;

    typedef struct {
        int h0;
        int v0;
        int hw0;
        int h1;
        int v1;
        int hw1;
    } exp_t;

    logic clk;
    logic reset;

    ball_if #(.h_bits(10), .v_bits(10)) bus_a ();
    ball_if #(.h_bits(10), .v_bits(10)) bus_b ();

    ball_motion dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    ball_motion #(
        .init_x (1006),
        .init_y (750)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    int   init_x [2] = '{512, 1006};
    int   init_y [2] = '{384, 750};
    int   mx [2];
    int   my [2];
    int   mdx [2];
    int   mdy [2];
    int   cnt;
    exp_t q [$];

    int   n_checks;
    int   n_fail;

    int   cur_h [2];
    int   cur_v [2];
    bit   prev_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reflecting walk along one axis: land on the limit and turn around.
    function automatic void axis(input int pos, input int dir, input int lo,
                                 input int hi, input int st, output int np,
                                 output int nd, output int hlo, output int hhi);
        np  = pos;
        nd  = dir;
        hlo = 0;
        hhi = 0;
        if (dir > 0) begin
            if (pos + st >= hi) begin
                np  = hi;
                nd  = -1;
                hhi = 1;
            end else begin
                np = (pos + st < lo) ? lo : pos + st;
            end
        end else begin
            if (pos <= lo + st) begin
                np  = lo;
                nd  = 1;
                hlo = 1;
            end else begin
                np = (pos - st > hi) ? hi : pos - st;
            end
        end
    endfunction

    task automatic model_reset();
        cnt = 0;
        q.delete();
        for (int i = 0; i < 2; i++) begin
            mx[i]  = init_x[i];
            my[i]  = init_y[i];
            mdx[i] = 1;
            mdy[i] = 1;
        end
    endtask

    task automatic model_move();
        int   hw [2];
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            int nxp, ndx, hl, hr, nyp, ndy, ht, hb;
            axis(mx[i], mdx[i], X_LO, X_HI, ST, nxp, ndx, hl, hr);
            axis(my[i], mdy[i], Y_LO, Y_HI, ST, nyp, ndy, ht, hb);
            mx[i]  = nxp;
            mdx[i] = ndx;
            my[i]  = nyp;
            mdy[i] = ndy;
            hw[i]  = hl + 2 * hr + 4 * ht + 8 * hb;
        end
        e.h0  = mx[0];
        e.v0  = my[0];
        e.hw0 = hw[0];
        e.h1  = mx[1];
        e.v1  = my[1];
        e.hw1 = hw[1];
        q.push_back(e);
    endtask

    // Inputs change 2 time units after a rising edge; model tracks the same edge.
    task automatic step(input bit m, input bit en);
        bus_a.move    = m;
        bus_a.ball_en = en;
        bus_b.move    = m;
        bus_b.ball_en = en;
        @(posedge clk);
        if (cnt > 0) cnt--;
        else if (m && en) begin
            model_move();
            cnt = 3;
        end
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_h_a", int'(bus_a.h_pos), init_x[0]);
            chk("rst_v_a", int'(bus_a.v_pos), init_y[0]);
            chk("rst_busy_a", int'(bus_a.busy), 0);
            chk("rst_hit_a", int'(bus_a.hit_wall), 0);
            chk("rst_h_b", int'(bus_b.h_pos), init_x[1]);
            chk("rst_v_b", int'(bus_b.v_pos), init_y[1]);
            for (int i = 0; i < 2; i++) begin
                cur_h[i] = init_x[i];
                cur_v[i] = init_y[i];
            end
            prev_busy = 1'b0;
        end else begin
            int ehw0, ehw1;
            ehw0 = 0;
            ehw1 = 0;
            chk("busy_a", int'(bus_a.busy), int'(cnt != 0));
            chk("busy_b", int'(bus_b.busy), int'(cnt != 0));
            if (prev_busy && !bus_a.busy) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL commit_unexpected: got commit expected none at %0t", $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    cur_h[0] = e.h0;
                    cur_v[0] = e.v0;
                    cur_h[1] = e.h1;
                    cur_v[1] = e.v1;
                    ehw0     = e.hw0;
                    ehw1     = e.hw1;
                end
            end
            chk("h_a", int'(bus_a.h_pos), cur_h[0]);
            chk("v_a", int'(bus_a.v_pos), cur_v[0]);
            chk("hit_a", int'(bus_a.hit_wall), ehw0);
            chk("h_b", int'(bus_b.h_pos), cur_h[1]);
            chk("v_b", int'(bus_b.v_pos), cur_v[1]);
            chk("hit_b", int'(bus_b.hit_wall), ehw1);
            prev_busy = bus_a.busy;
        end
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        prev_busy     = 1'b0;
        reset         = 1'b1;
        bus_a.move    = 1'b0;
        bus_a.ball_en = 1'b0;
        bus_b.move    = 1'b0;
        bus_b.ball_en = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            cur_h[i] = init_x[i];
            cur_v[i] = init_y[i];
        end
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        repeat (100) step(1'b0, 1'b1);

        // single move, then ten back-to-back accepted moves
        step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1);
            repeat (3) step(1'b0, 1'b1);
        end
        repeat (4) step(1'b0, 1'b1);

        // strobe while busy is dropped; disabled strobe is dropped
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);

        // enable falls mid-update
        step(1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b0);

        // reset lands while the update sits in CALC_Y
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        do_reset();
        step(1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b1);

        for (int k = 0; k < 8000; k++) begin
            if ($urandom_range(0, 1999) == 0) do_reset();
            else step($urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0);
        end

        repeat (10) step(1'b0, 1'b1);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
